i2c_key_rx_controller: RTL and testbench
========================================

# i2c_key_rx_controller

Sequences the I2C slave receive path around the bit/byte timer. It consumes the timer's start/stop and byte-phase strobes (`byte_received`, `ack_prep`, `check_ack`, `ack_done`) and the parallel byte from the receive shift register. It decides address match and drives the SDA ACK. It assembles two-byte keys and hands them to the downstream consumer with a valid/ready handshake, and it pulses `start_byte_received` back to the timer to arm key counting.

## Interface
- `SLAVE_ADDR`, default 7'h2A: 7-bit bus address this slave answers to.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `n_rst`  in  1  asynchronous, active-low reset.
- `start_found`  in  1  one-cycle pulse on a START or repeated START.
- `stop_found`  in  1  one-cycle pulse on a STOP.
- `byte_received`  in  1  timer pulse: 8th data bit sampled, `rx_data` valid this cycle.
- `ack_prep`  in  1  timer pulse: SCL low after the 8th bit; ACK may be driven.
- `check_ack`  in  1  timer pulse: ACK clock high. Ignored; this block is write-only.
- `ack_done`  in  1  timer pulse: ACK clock finished.
- `rx_data`  in  8  parallel byte from the shift register, MSB first on the wire.
- `key_ready`  in  1  downstream accepts the key when it is high together with `key_valid`.
- `start_byte_received`  out  1  one-cycle pulse to the timer after an accepted address byte.
- `sda_mode`  out  2  00 = release SDA, 01 = drive SDA low (ACK). 10 and 11 are never produced.
- `key_data`  out  16  assembled key: first byte in [15:8], second byte in [7:0].
- `key_valid`  out  1  key available; held until the handshake completes.
- `overrun`  out  1  sticky: a key was dropped because the previous key was still pending.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- States: IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE.
- IDLE → ADDR on `start_found`.
- ADDR → ADDR_ACK on `byte_received` when `rx_data[7:1]==SLAVE_ADDR` and `rx_data[0]==0`.
  - In the same transition, `start_byte_received` pulses on the next cycle and `byte_idx` clears to 0.
  - Any other `rx_data` (wrong address or R/W=1) → IGNORE, with no ACK.
- ADDR_ACK and DATA_ACK: `sda_mode` goes to 01 on the cycle after `ack_prep` and holds until the cycle after `ack_done`, then returns to 00. `ack_done` then moves the FSM to DATA.
- DATA on `byte_received`:
  - `byte_idx==0`: latch `rx_data` into the key high byte, set `byte_idx`=1, go to DATA_ACK with ACK.
  - `byte_idx==1` and (`key_valid==0` or `key_ready==1` this cycle): latch the low byte, go to DATA_ACK with ACK. On that DATA_ACK's `ack_done`, load `key_data`, assert `key_valid`, and set `byte_idx`=0.
  - `byte_idx==1` and the previous key is still pending: set `overrun`, discard both bytes, set `byte_idx`=0, go to DATA_ACK without ACK (NACK, `sda_mode` stays 00).
- Handshake: `key_valid` clears on the cycle after `key_valid & key_ready`. `key_data` is stable while `key_valid` is high.
- `stop_found` in any state → IDLE. It releases SDA and discards a partial key (`byte_idx`=0).
- `start_found` in any state → ADDR (repeated start). It releases SDA and discards a partial key.
- `overrun` clears only on `start_found` or reset.
- `start_found` and `stop_found` in the same cycle: `start_found` wins (→ ADDR).
- Timer strobes that arrive in a state that does not expect them are ignored (e.g. `ack_prep` in DATA, `byte_received` in IGNORE).
- A pending `key_valid` survives STOP/START and is cleared only by the handshake or reset.

## Timing
- Reset values: IDLE, `byte_idx`=0, and every output 0 (`sda_mode`=00, `key_data`=16'h0000).
- All outputs are registered; there is no combinational input-to-output path.
- `start_byte_received`: exactly one cycle, one cycle after the accepting `byte_received`.
- ACK drive window: from the cycle after `ack_prep` through the cycle of `ack_done` inclusive, then released on the next edge.
- `key_valid` rises one cycle after the second byte's `ack_done`.
- Asynchronous reset mid-ACK releases SDA immediately (`sda_mode`=00) and drops any pending key.

## Test plan
- START; address byte 8'h54 (addr 2A, W); then 8'hBE and 8'hEF with `key_ready`=1.
  - Required: one `start_byte_received` pulse, and three ACK windows, each with `sda_mode`=01 from `ack_prep`+1 to `ack_done`.
  - Required: `key_data`=16'hBEEF and a one-cycle `key_valid`.
- Address 8'h55 (R/W=1) and address 8'h56 → no `start_byte_received`, `sda_mode` stays 00 throughout, state IGNORE until STOP.
- With `key_ready`=0, send four data bytes 11,22,33,44.
  - Required: first key 16'h1122 held valid; the 4th byte is NACKed; `overrun`=1.
  - Required: `key_data` stays 16'h1122 until `key_ready`, and `overrun` clears on the next START.
- Send one data byte 8'hAA, then STOP, then START, address, 8'h01, 8'h02 → `key_data`=16'h0102 (the partial byte 8'hAA is discarded).
- Assert `start_found` and `stop_found` together → `busy`=1, state ADDR. `stop_found` during an ACK window → `sda_mode`=00 on the next cycle.
- Assert `n_rst` low between `ack_prep` and `ack_done` → all outputs 0 immediately, state IDLE, and later strobes are ignored until `start_found`.

Source files
------------

// File: rtl/i2c_key_rx_controller_if.sv
// ---------------------------------------------------------------------------
// i2c_key_rx_controller_if
// Bundles the timer strobes, receive byte, key handshake and status outputs
// of the I2C key receive controller.
//   master : the side that drives the timer strobes and key_ready
//            (bit/byte timer plus the downstream consumer, or a testbench)
//   slave  : the controller itself
// Signals:
//   start_found, stop_found      bus condition pulses
//   byte_received, ack_prep,
//   check_ack, ack_done          byte-phase strobes from the timer
//   rx_data[7:0]                 parallel byte from the receive shifter
//   key_ready                    downstream accept
//   start_byte_received          pulse back to the timer after an address ACK
//   sda_mode[1:0]                00 release, 01 drive low
//   key_data[15:0], key_valid    assembled key and its valid flag
//   overrun, busy                status
// ---------------------------------------------------------------------------
interface i2c_key_rx_controller_if;
    logic        start_found;
    logic        stop_found;
    logic        byte_received;
    logic        ack_prep;
    logic        check_ack;
    logic        ack_done;
    logic [7:0]  rx_data;
    logic        key_ready;
    logic        start_byte_received;
    logic [1:0]  sda_mode;
    logic [15:0] key_data;
    logic        key_valid;
    logic        overrun;
    logic        busy;

    modport master (
        output start_found, stop_found, byte_received, ack_prep, check_ack,
               ack_done, rx_data, key_ready,
        input  start_byte_received, sda_mode, key_data, key_valid, overrun,
               busy
    );

    modport slave (
        input  start_found, stop_found, byte_received, ack_prep, check_ack,
               ack_done, rx_data, key_ready,
        output start_byte_received, sda_mode, key_data, key_valid, overrun,
               busy
    );
endinterface

// File: rtl/i2c_key_rx_controller.sv
// ---------------------------------------------------------------------------
// i2c_key_rx_controller
// Write-only I2C slave receive sequencer. Follows the byte phases reported by
// the bit/byte timer, matches the address, drives the SDA ACK, and assembles
// pairs of data bytes into 16-bit keys offered downstream with valid/ready.
// Ports:
//   clk    system clock, rising edge
//   n_rst  asynchronous active-low reset
//   bus    i2c_key_rx_controller_if.slave (strobes in, key/status out)
// Parameter:
//   SLAVE_ADDR  7-bit bus address answered to (write direction only)
// ---------------------------------------------------------------------------
module i2c_key_rx_controller #(
    parameter logic [6:0] SLAVE_ADDR = 7'h2A
) (
    input  logic                          clk,
    input  logic                          n_rst,
    i2c_key_rx_controller_if.slave        bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_DATA,
        S_DATA_ACK,
        S_IGNORE
    } state_t;

    localparam logic [1:0] SDA_RELEASE = 2'b00;
    localparam logic [1:0] SDA_LOW     = 2'b01;

    state_t      state_reg;
    state_t      state_next;

    logic        byte_idx_reg;     // 0: expecting key high byte, 1: low byte
    logic [7:0]  key_hi_reg;
    logic [7:0]  key_lo_reg;
    logic        ack_en_reg;       // current ACK phase drives SDA low
    logic        commit_reg;       // current ACK phase completes a key
    logic [1:0]  sda_mode_reg;
    logic        sbr_reg;
    logic [15:0] key_data_reg;
    logic        key_valid_reg;
    logic        overrun_reg;
    logic        busy_reg;

    logic        addr_match;
    logic        key_slot_free;
    logic        unused_check_ack;

    // The ACK-clock-high strobe carries no information for a write-only slave.
    assign unused_check_ack = bus.check_ack;

    assign addr_match    = (bus.rx_data[7:1] == SLAVE_ADDR) && !bus.rx_data[0];
    // The pending key will be gone by the time the new one is loaded if the
    // consumer takes it in this very cycle.
    assign key_slot_free = !key_valid_reg || bus.key_ready;

    // Next-state decode. START beats STOP, and both beat every timer strobe.
    always_comb begin
        state_next = state_reg;
        if (bus.start_found) begin
            state_next = S_ADDR;
        end else if (bus.stop_found) begin
            state_next = S_IDLE;
        end else begin
            case (state_reg)
                S_ADDR: begin
                    if (bus.byte_received) begin
                        state_next = addr_match ? S_ADDR_ACK : S_IGNORE;
                    end
                end
                S_ADDR_ACK, S_DATA_ACK: begin
                    if (bus.ack_done) begin
                        state_next = S_DATA;
                    end
                end
                S_DATA: begin
                    if (bus.byte_received) begin
                        state_next = S_DATA_ACK;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_reg     <= S_IDLE;
            byte_idx_reg  <= 1'b0;
            key_hi_reg    <= 8'h00;
            key_lo_reg    <= 8'h00;
            ack_en_reg    <= 1'b0;
            commit_reg    <= 1'b0;
            sda_mode_reg  <= SDA_RELEASE;
            sbr_reg       <= 1'b0;
            key_data_reg  <= 16'h0000;
            key_valid_reg <= 1'b0;
            overrun_reg   <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            state_reg <= state_next;
            busy_reg  <= (state_next != S_IDLE);
            sbr_reg   <= 1'b0;

            // Handshake runs regardless of bus activity so a pending key
            // survives STOP/START. A load later in this block overrides it.
            if (key_valid_reg && bus.key_ready) begin
                key_valid_reg <= 1'b0;
            end

            if (bus.start_found) begin
                sda_mode_reg <= SDA_RELEASE;
                byte_idx_reg <= 1'b0;
                ack_en_reg   <= 1'b0;
                commit_reg   <= 1'b0;
                overrun_reg  <= 1'b0;
            end else if (bus.stop_found) begin
                sda_mode_reg <= SDA_RELEASE;
                byte_idx_reg <= 1'b0;
                ack_en_reg   <= 1'b0;
                commit_reg   <= 1'b0;
            end else begin
                case (state_reg)
                    S_ADDR: begin
                        if (bus.byte_received && addr_match) begin
                            sbr_reg      <= 1'b1;
                            byte_idx_reg <= 1'b0;
                            ack_en_reg   <= 1'b1;
                            commit_reg   <= 1'b0;
                        end
                    end

                    S_ADDR_ACK, S_DATA_ACK: begin
                        if (bus.ack_done) begin
                            sda_mode_reg <= SDA_RELEASE;
                            ack_en_reg   <= 1'b0;
                            commit_reg   <= 1'b0;
                            if (commit_reg) begin
                                key_data_reg  <= {key_hi_reg, key_lo_reg};
                                key_valid_reg <= 1'b1;
                                byte_idx_reg  <= 1'b0;
                            end
                        end else if (bus.ack_prep && ack_en_reg) begin
                            sda_mode_reg <= SDA_LOW;
                        end
                    end

                    S_DATA: begin
                        if (bus.byte_received) begin
                            if (!byte_idx_reg) begin
                                key_hi_reg   <= bus.rx_data;
                                byte_idx_reg <= 1'b1;
                                ack_en_reg   <= 1'b1;
                                commit_reg   <= 1'b0;
                            end else if (key_slot_free) begin
                                // byte_idx stays 1 until the key is loaded
                                key_lo_reg <= bus.rx_data;
                                ack_en_reg <= 1'b1;
                                commit_reg <= 1'b1;
                            end else begin
                                // Consumer still holds the last key: drop
                                // this one and NACK its second byte.
                                overrun_reg  <= 1'b1;
                                byte_idx_reg <= 1'b0;
                                ack_en_reg   <= 1'b0;
                                commit_reg   <= 1'b0;
                            end
                        end
                    end

                    default: ;
                endcase
            end
        end
    end

    assign bus.start_byte_received = sbr_reg;
    assign bus.sda_mode            = sda_mode_reg;
    assign bus.key_data            = key_data_reg;
    assign bus.key_valid           = key_valid_reg;
    assign bus.overrun             = overrun_reg;
    assign bus.busy                = busy_reg;

endmodule

// File: tb/tb_i2c_key_rx_controller.sv
// ---------------------------------------------------------------------------
// tb_i2c_key_rx_controller
// Drives timer-style byte phases into i2c_key_rx_controller. A transaction
// level model predicts ACK/NACK per byte, address acceptance pulses and the
// keys handed downstream; expectations go into queues that a negedge monitor
// pops and compares against the DUT outputs.
// ---------------------------------------------------------------------------
module tb_i2c_key_rx_controller;

    localparam logic [6:0] SLAVE = 7'h2A;

    // model bus phase
    localparam int M_IDLE   = 0;
    localparam int M_ADDR   = 1;
    localparam int M_DATA   = 2;
    localparam int M_IGNORE = 3;

    // ids for direct output checks
    localparam int SIG_SDA  = 0;
    localparam int SIG_KD   = 1;
    localparam int SIG_KV   = 2;
    localparam int SIG_OVR  = 3;
    localparam int SIG_BUSY = 4;
    localparam int SIG_SBR  = 5;

    typedef struct {
        int          sig;
        logic [15:0] exp;
    } chk_t;

    logic clk;
    logic n_rst;

    i2c_key_rx_controller_if bus ();

    i2c_key_rx_controller #(.SLAVE_ADDR(SLAVE)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard queues (driver pushes, monitor pops)
    logic [15:0] exp_keys[$];
    bit          exp_ack[$];
    bit          exp_sbr[$];
    chk_t        chk_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    bit tb_addr_phase = 1'b0;
    bit do_final      = 1'b0;

    // ---------------- reference model state ----------------
    int         m_st      = M_IDLE;
    bit         m_have_hi = 1'b0;
    logic [7:0] m_hi      = 8'h00;
    bit         m_pend    = 1'b0;   // a key is waiting for the consumer
    bit         m_ovr     = 1'b0;
    bit         m_deliver = 1'b0;   // next edge hands a key downstream

    function automatic string sig_name(input int s);
        case (s)
            SIG_SDA:  return "sda_mode";
            SIG_KD:   return "key_data";
            SIG_KV:   return "key_valid";
            SIG_OVR:  return "overrun";
            SIG_BUSY: return "busy";
            default:  return "start_byte_received";
        endcase
    endfunction

    function automatic logic [15:0] sig_val(input int s);
        case (s)
            SIG_SDA:  return {14'b0, bus.sda_mode};
            SIG_KD:   return bus.key_data;
            SIG_KV:   return {15'b0, bus.key_valid};
            SIG_OVR:  return {15'b0, bus.overrun};
            SIG_BUSY: return {15'b0, bus.busy};
            default:  return {15'b0, bus.start_byte_received};
        endcase
    endfunction

    task automatic check(input string name, input logic [15:0] act,
                         input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_out(input int s, input logic [15:0] v);
        chk_t c;
        c.sig = s;
        c.exp = v;
        chk_q.push_back(c);
    endtask

    // ---------------- driver helpers ----------------
    task automatic tick();
        bit cons;
        cons = m_pend && bus.key_ready;
        @(posedge clk);
        #1;
        if (cons) m_pend = 1'b0;
        if (m_deliver) begin
            m_pend    = 1'b1;
            m_deliver = 1'b0;
        end
        bus.start_found   = 1'b0;
        bus.stop_found    = 1'b0;
        bus.byte_received = 1'b0;
        bus.ack_prep      = 1'b0;
        bus.check_ack     = 1'b0;
        bus.ack_done      = 1'b0;
    endtask

    task automatic start_cond();
        bus.start_found = 1'b1;
        m_st      = M_ADDR;
        m_have_hi = 1'b0;
        m_ovr     = 1'b0;
        tick();
    endtask

    task automatic stop_cond();
        bus.stop_found = 1'b1;
        m_st      = M_IDLE;
        m_have_hi = 1'b0;
        tick();
    endtask

    task automatic model_reset();
        exp_keys.delete();
        exp_ack.delete();
        exp_sbr.delete();
        chk_q.delete();
        m_st      = M_IDLE;
        m_have_hi = 1'b0;
        m_pend    = 1'b0;
        m_ovr     = 1'b0;
        m_deliver = 1'b0;
    endtask

    // mode 0: full byte phase; 1: STOP inside the ACK window;
    // 2: reset inside the ACK window (caller releases reset)
    task automatic send_byte(input logic [7:0] b, input int mode);
        bit ack;
        bit deliver;
        ack     = 1'b0;
        deliver = 1'b0;
        tb_addr_phase = (m_st == M_ADDR);
        case (m_st)
            M_ADDR: begin
                if (b[7:1] == SLAVE && b[0] == 1'b0) begin
                    ack = 1'b1;
                    exp_sbr.push_back(1'b1);
                    m_st = M_DATA;
                    m_have_hi = 1'b0;
                end else begin
                    exp_sbr.push_back(1'b0);
                    m_st = M_IGNORE;
                end
            end
            M_DATA: begin
                if (!m_have_hi) begin
                    m_hi = b;
                    m_have_hi = 1'b1;
                    ack = 1'b1;
                end else if (!m_pend || bus.key_ready) begin
                    ack = 1'b1;
                    exp_keys.push_back({m_hi, b});
                    deliver = 1'b1;
                    m_have_hi = 1'b0;
                end else begin
                    m_ovr = 1'b1;
                    m_have_hi = 1'b0;
                end
            end
            default: ;
        endcase
        exp_ack.push_back(ack);

        bus.rx_data = b;
        bus.byte_received = 1'b1;
        tick();
        tb_addr_phase = 1'b0;
        repeat ($urandom_range(0, 2)) tick();
        bus.ack_prep = 1'b1;
        tick();
        if (mode == 1) begin
            tick();
            if (deliver) void'(exp_keys.pop_back());
            stop_cond();
            expect_out(SIG_SDA, 16'd0);
            expect_out(SIG_BUSY, 16'd0);
        end else if (mode == 2) begin
            tick();
            tick();
            n_rst = 1'b0;
            model_reset();
            expect_out(SIG_SDA, 16'd0);
            expect_out(SIG_KD, 16'd0);
            expect_out(SIG_KV, 16'd0);
            expect_out(SIG_OVR, 16'd0);
            expect_out(SIG_BUSY, 16'd0);
            expect_out(SIG_SBR, 16'd0);
        end else begin
            repeat ($urandom_range(1, 3)) begin
                bus.check_ack = 1'($urandom_range(0, 1));
                tick();
            end
            bus.ack_done = 1'b1;
            m_deliver = deliver;
            tick();
            repeat ($urandom_range(0, 2)) tick();
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    bit          win_active   = 1'b0;
    bit          win_exp      = 1'b0;
    bit          prev_addr_br = 1'b0;
    bit          hold_valid   = 1'b0;
    logic [15:0] hold_data    = 16'h0;
    bit          final_done   = 1'b0;
    chk_t        cur;

    always @(negedge clk) begin
        while (chk_q.size() != 0) begin
            cur = chk_q.pop_front();
            check(sig_name(cur.sig), sig_val(cur.sig), cur.exp);
        end
        if (!n_rst) begin
            win_active   = 1'b0;
            prev_addr_br = 1'b0;
            hold_valid   = 1'b0;
        end else begin
            // SDA: low only inside an ACKed window, released elsewhere
            check("sda_mode", {14'b0, bus.sda_mode},
                  (win_active && win_exp) ? 16'd1 : 16'd0);
            if (win_active && (bus.ack_done || bus.start_found || bus.stop_found)) begin
                win_active = 1'b0;
            end else if (!win_active && bus.ack_prep) begin
                check("ack_expectation_present", 16'(exp_ack.size() != 0), 16'd1);
                if (exp_ack.size() != 0) begin
                    win_exp    = exp_ack.pop_front();
                    win_active = 1'b1;
                end
            end

            // start_byte_received: one cycle after an address byte, else 0
            if (prev_addr_br) begin
                check("sbr_expectation_present", 16'(exp_sbr.size() != 0), 16'd1);
                if (exp_sbr.size() != 0)
                    check("start_byte_received", {15'b0, bus.start_byte_received},
                          {15'b0, exp_sbr.pop_front()});
            end else begin
                check("start_byte_received_idle", {15'b0, bus.start_byte_received}, 16'd0);
            end
            prev_addr_br = bus.byte_received && tb_addr_phase;

            // a held key must not change
            if (hold_valid) begin
                check("key_valid_held", {15'b0, bus.key_valid}, 16'd1);
                check("key_data_held", bus.key_data, hold_data);
            end
            hold_valid = bus.key_valid && !bus.key_ready;
            hold_data  = bus.key_data;

            // handshake: pop the predicted key
            if (bus.key_valid && bus.key_ready) begin
                check("key_expected", 16'(exp_keys.size() != 0), 16'd1);
                if (exp_keys.size() != 0)
                    check("key_data", bus.key_data, exp_keys.pop_front());
            end
        end
        if (do_final && !final_done) begin
            final_done = 1'b1;
            check("keys_outstanding", 16'(exp_keys.size()), 16'd0);
            check("acks_outstanding", 16'(exp_ack.size()), 16'd0);
            check("sbr_outstanding", 16'(exp_sbr.size()), 16'd0);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        bus.start_found   = 1'b0;
        bus.stop_found    = 1'b0;
        bus.byte_received = 1'b0;
        bus.ack_prep      = 1'b0;
        bus.check_ack     = 1'b0;
        bus.ack_done      = 1'b0;
        bus.rx_data       = 8'h00;
        bus.key_ready     = 1'b0;
        n_rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_rst = 1'b1;
        expect_out(SIG_SDA, 16'd0);
        expect_out(SIG_KD, 16'd0);
        expect_out(SIG_KV, 16'd0);
        expect_out(SIG_OVR, 16'd0);
        expect_out(SIG_BUSY, 16'd0);
        expect_out(SIG_SBR, 16'd0);
        tick();

        // basic key with consumer ready
        bus.key_ready = 1'b1;
        start_cond();
        expect_out(SIG_BUSY, 16'd1);
        send_byte(8'h54, 0);
        send_byte(8'hBE, 0);
        send_byte(8'hEF, 0);
        stop_cond();
        expect_out(SIG_BUSY, 16'd0);
        tick();

        // read direction and wrong address are ignored
        start_cond();
        send_byte(8'h55, 0);
        expect_out(SIG_BUSY, 16'd1);
        send_byte(8'h12, 0);
        stop_cond();
        start_cond();
        send_byte(8'h56, 0);
        send_byte(8'h34, 0);
        stop_cond();
        expect_out(SIG_BUSY, 16'd0);
        tick();

        // overrun with a stalled consumer
        bus.key_ready = 1'b0;
        start_cond();
        send_byte(8'h54, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        send_byte(8'h33, 0);
        send_byte(8'h44, 0);
        expect_out(SIG_OVR, 16'd1);
        expect_out(SIG_KD, 16'h1122);
        expect_out(SIG_KV, 16'd1);
        repeat (3) tick();
        bus.key_ready = 1'b1;
        repeat (3) tick();
        expect_out(SIG_OVR, 16'd1);
        start_cond();
        expect_out(SIG_OVR, 16'd0);
        stop_cond();

        // partial key dropped by STOP
        start_cond();
        send_byte(8'h54, 0);
        send_byte(8'hAA, 0);
        stop_cond();
        start_cond();
        send_byte(8'h54, 0);
        send_byte(8'h01, 0);
        send_byte(8'h02, 0);
        stop_cond();
        tick();

        // simultaneous START and STOP, then STOP inside an ACK window
        bus.start_found = 1'b1;
        bus.stop_found  = 1'b1;
        m_st = M_ADDR;
        m_have_hi = 1'b0;
        m_ovr = 1'b0;
        tick();
        expect_out(SIG_BUSY, 16'd1);
        send_byte(8'h54, 0);
        send_byte(8'h11, 1);
        tick();

        // reset inside an ACK window while a key is pending
        bus.key_ready = 1'b0;
        start_cond();
        send_byte(8'h54, 0);
        send_byte(8'hAB, 0);
        send_byte(8'hCD, 0);
        send_byte(8'h77, 2);
        tick();
        tick();
        n_rst = 1'b1;
        bus.key_ready = 1'b1;
        send_byte(8'h54, 0);          // no START yet: must be ignored
        expect_out(SIG_BUSY, 16'd0);
        expect_out(SIG_KV, 16'd0);
        start_cond();
        send_byte(8'h54, 0);
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        stop_cond();

        // randomized transactions
        for (int t = 0; t < 40; t++) begin
            start_cond();
            bus.key_ready = 1'($urandom_range(0, 1));
            send_byte(($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h54, 0);
            for (int k = 0; k < int'($urandom_range(0, 5)); k++) begin
                bus.key_ready = ($urandom_range(0, 2) != 0);
                send_byte(8'($urandom), 0);
            end
            expect_out(SIG_OVR, {15'b0, m_ovr});
            if ($urandom_range(0, 2) != 0) stop_cond();
            repeat ($urandom_range(0, 3)) tick();
        end
        stop_cond();

        bus.key_ready = 1'b1;
        repeat (5) tick();
        do_final = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

endmodule
